core_dispatch: RTL and testbench

CORE_DISPATCH -- requirements
Module: core_dispatch

---
 rtl/core_dispatch.sv | 259 +++++++++++++++++++++++++
 tb/tb_core_dispatch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : core_dispatch
//  Purpose  : Accepts one command at a time and routes it to the core that owns
//             the address region (idx = address >> REGION_BITS). It then waits
//             for that core's done strobe, or for a timeout, and returns a
//             single result/status strobe.
//             Optional: define DISPATCH_BROADCAST_EN so that an all-ones address
//             issues the command to every core and collects a sticky done mask.
//  Ports    : clk_i, rst_i            - clock, synchronous active-high reset
//             cmd_valid_i/cmd_ready_o - command handshake (ready only in IDLE)
//             instruction_i, address_i, value_i - command fields
//             core_valid_o            - one-hot issue strobe (all ones on broadcast)
//             core_instruction_o, core_address_o (region-local), core_value_o
//             core_done_i, core_result_i - per-core completion and result slices
//             result_o, result_valid_o, status_o (00 OK, 01 TIMEOUT, 10 UNMAPPED)
//  Revision : 1.0 - initial release
// ============================================================================
module core_dispatch #(
    parameter int NUM_CORES   = 4,
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int REGION_BITS = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [7:0]                  instruction_i,
    input  logic [ADDR_W-1:0]           address_i,
    input  logic [DATA_W-1:0]           value_i,
    output logic [NUM_CORES-1:0]        core_valid_o,
    output logic [7:0]                  core_instruction_o,
    output logic [ADDR_W-1:0]           core_address_o,
    output logic [DATA_W-1:0]           core_value_o,
    input  logic [NUM_CORES-1:0]        core_done_i,
    input  logic [NUM_CORES*DATA_W-1:0] core_result_i,
    output logic [DATA_W-1:0]           result_o,
    output logic                        result_valid_o,
    output logic [1:0]                  status_o
);

    localparam logic [15:0] c_TIMEOUT     = 16'(TIMEOUT);
    localparam logic [1:0]  c_ST_OK       = 2'b00;
    localparam logic [1:0]  c_ST_TIMEOUT  = 2'b01;
    localparam logic [1:0]  c_ST_UNMAPPED = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [7:0]            r_instr;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_value;
    logic [NUM_CORES-1:0]  r_sel;       // target core(s), one-hot or all ones
    logic [15:0]           r_timer;
    logic [DATA_W-1:0]     r_result;
    logic [1:0]            r_status;

    logic [ADDR_W-1:0]     w_idx;
    logic [NUM_CORES-1:0]  w_sel_dec;
    logic                  w_mapped;
    logic                  w_go_issue;
    logic [ADDR_W-1:0]     w_local_addr;
    logic [NUM_CORES-1:0]  w_done_now;
    logic                  w_hit;
    logic                  w_timeout;
    logic [DATA_W-1:0]     w_core_result;

`ifdef DISPATCH_BROADCAST_EN
    logic                  r_bcast;
    logic [NUM_CORES-1:0]  r_done_mask;
    logic                  w_bcast;
    logic [NUM_CORES-1:0]  w_mask_acc;
    logic [DATA_W-1:0]     w_mask_ext;
`endif

    // ------------------------------------------------------------------
    // Address decode. A one-hot compare per core replaces the
    // "idx >= NUM_CORES" test: an empty select vector means unmapped.
    // ------------------------------------------------------------------
    always_comb begin
        w_idx        = address_i >> REGION_BITS;
        w_local_addr = ADDR_W'(address_i[REGION_BITS-1:0]);
        w_sel_dec    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_sel_dec[i] = (w_idx == ADDR_W'(i));
        end
        w_mapped = |w_sel_dec;
`ifdef DISPATCH_BROADCAST_EN
        w_bcast    = &address_i;
        w_go_issue = w_mapped | w_bcast;
`else
        w_go_issue = w_mapped;
`endif
    end

    // ------------------------------------------------------------------
    // Completion detect. Only done bits of the selected core(s) count.
    // ------------------------------------------------------------------
    always_comb begin
        w_done_now    = core_done_i & r_sel;
        w_timeout     = (r_timer == c_TIMEOUT);
        w_core_result = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (r_sel[i]) begin
                w_core_result = core_result_i[i*DATA_W +: DATA_W];
            end
        end
`ifdef DISPATCH_BROADCAST_EN
        // Include this cycle's done bits so a completion on the final
        // cycle is credited both to the all-done test and to the mask.
        w_mask_acc = r_done_mask | w_done_now;
        w_mask_ext = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (i < DATA_W) begin
                w_mask_ext[i] = w_mask_acc[i];
            end
        end
        w_hit = r_bcast ? (&w_mask_acc) : (|w_done_now);
`else
        w_hit = |w_done_now;
`endif
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. Every output is forced low while reset is
    // held, so the block is silent even before the first reset edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        cmd_ready_o        = 1'b0;
        core_valid_o       = '0;
        result_valid_o     = 1'b0;
        core_instruction_o = '0;
        core_address_o     = '0;
        core_value_o       = '0;
        result_o           = '0;
        status_o           = '0;

        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_state_nxt = w_go_issue ? S_ISSUE : S_RESPOND;
                end
            end
            S_ISSUE:   w_state_nxt = S_WAIT;
            S_WAIT: begin
                // Done is tested first so it wins over a coincident timeout.
                if (w_hit || w_timeout) begin
                    w_state_nxt = S_RESPOND;
                end
            end
            S_RESPOND: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase

        if (!rst_i) begin
            cmd_ready_o        = (r_state == S_IDLE);
            core_valid_o       = (r_state == S_ISSUE) ? r_sel : '0;
            result_valid_o     = (r_state == S_RESPOND);
            core_instruction_o = r_instr;
            core_address_o     = r_addr;
            core_value_o       = r_value;
            result_o           = r_result;
            status_o           = r_status;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_instr  <= '0;
            r_addr   <= '0;
            r_value  <= '0;
            r_sel    <= '0;
            r_timer  <= '0;
            r_result <= '0;
            r_status <= '0;
`ifdef DISPATCH_BROADCAST_EN
            r_bcast     <= 1'b0;
            r_done_mask <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_instr <= instruction_i;
                        r_value <= value_i;
                        r_addr  <= w_local_addr;
                        r_sel   <= w_sel_dec;
`ifdef DISPATCH_BROADCAST_EN
                        r_bcast     <= w_bcast;
                        r_done_mask <= '0;
                        if (w_bcast) begin
                            r_addr <= '0;
                            r_sel  <= '1;
                        end
`endif
                        if (!w_go_issue) begin
                            r_result <= '0;
                            r_status <= c_ST_UNMAPPED;
                        end
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 16'd1;
`ifdef DISPATCH_BROADCAST_EN
                    r_done_mask <= w_mask_acc;
`endif
                    if (w_hit) begin
                        r_status <= c_ST_OK;
                        r_result <= w_core_result;
`ifdef DISPATCH_BROADCAST_EN
                        if (r_bcast) begin
                            r_result <= DATA_W'(NUM_CORES);
                        end
`endif
                    end else if (w_timeout) begin
                        r_status <= c_ST_TIMEOUT;
                        r_result <= '0;
`ifdef DISPATCH_BROADCAST_EN
                        if (r_bcast) begin
                            r_result <= w_mask_ext;
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_dispatch
//  Purpose  : Directed scoreboard bench for core_dispatch (default parameters).
//             Stimulus pushes expected issues/results into queues; a negedge
//             monitor pops and compares whenever the DUT strobes an output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_dispatch;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [7:0]   instr = '0;
    logic [23:0]  addr = '0;
    logic [31:0]  val = '0;
    logic [3:0]   core_valid;
    logic [7:0]   core_instr;
    logic [23:0]  core_addr;
    logic [31:0]  core_val;
    logic [3:0]   core_done = '0;
    logic [127:0] core_result = '0;
    logic [31:0]  result;
    logic         result_valid;
    logic [1:0]   status;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0]  mask;
        logic [23:0] addr;
        logic [7:0]  instr;
        logic [31:0] val;
        logic [31:0] cyc;
    } iss_t;

    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  st;
        logic [31:0] cyc;
    } res_t;

    iss_t exp_iss[$];
    res_t exp_res[$];

    core_dispatch dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cmd_valid_i        (cmd_valid),
        .cmd_ready_o        (cmd_ready),
        .instruction_i      (instr),
        .address_i          (addr),
        .value_i            (val),
        .core_valid_o       (core_valid),
        .core_instruction_o (core_instr),
        .core_address_o     (core_addr),
        .core_value_o       (core_val),
        .core_done_i        (core_done),
        .core_result_i      (core_result),
        .result_o           (result),
        .result_valid_o     (result_valid),
        .status_o           (status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    // Presents a command for one cycle; c0 is the accept cycle.
    task automatic send(input logic [23:0] a, input logic [7:0] i, input logic [31:0] v,
                        output int c0);
        chk("cmd_ready", cmd_ready, 1);
        c0 = cyc;
        cmd_valid = 1'b1;
        addr = a;
        instr = i;
        val = v;
        tick();
        cmd_valid = 1'b0;
        // Scramble the inputs so the issue fields must come from registers.
        addr = ~a;
        instr = ~i;
        val = ~v;
    endtask

    task automatic pulse_done(input int n, input logic [31:0] d);
        core_result[n*32 +: 32] = d;
        core_done[n] = 1'b1;
        tick();
        core_done[n] = 1'b0;
    endtask

    task automatic expect_issue(input logic [3:0] m, input logic [23:0] a, input logic [7:0] i,
                                input logic [31:0] v, input int c);
        iss_t e;
        e.mask = m; e.addr = a; e.instr = i; e.val = v; e.cyc = 32'(c);
        exp_iss.push_back(e);
    endtask

    task automatic expect_res(input logic [31:0] r, input logic [1:0] s, input int c);
        res_t e;
        e.res = r; e.st = s; e.cyc = 32'(c);
        exp_res.push_back(e);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        iss_t ei;
        res_t er;
        if (core_valid !== 4'b0000) begin
            if (exp_iss.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_issue: got core_valid=%b expected none (cycle %0d)",
                         core_valid, cyc);
            end else begin
                ei = exp_iss.pop_front();
                chk("issue_mask",  64'(core_valid), 64'(ei.mask));
                chk("issue_addr",  64'(core_addr),  64'(ei.addr));
                chk("issue_instr", 64'(core_instr), 64'(ei.instr));
                chk("issue_value", 64'(core_val),   64'(ei.val));
                chk("issue_cycle", 64'(cyc),        64'(ei.cyc));
            end
        end
        if (result_valid !== 1'b0) begin
            if (exp_res.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_result: got result=0x%0h status=%b expected none (cycle %0d)",
                         result, status, cyc);
            end else begin
                er = exp_res.pop_front();
                chk("result_value",  64'(result), 64'(er.res));
                chk("result_status", 64'(status), 64'(er.st));
                chk("result_cycle",  64'(cyc),    64'(er.cyc));
            end
        end
    end

    initial begin : wdog
        #200000;
        n_bad++;
        $display("FAIL watchdog: got no completion expected completion by 200000ns");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : stim
        int c0;
        int c1;
        for (int n = 0; n < 4; n++) core_result[n*32 +: 32] = 32'hD0D0_0000 | 32'(n);

        // Reset: everything silent, ready as soon as reset drops.
        repeat (3) tick();
        chk("rst_ready",        cmd_ready, 0);
        chk("rst_core_valid",   core_valid, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result",       result, 0);
        chk("rst_status",       status, 0);
        chk("rst_core_addr",    core_addr, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", cmd_ready, 1);
        tick();

        // Core 2 completes 5 cycles after issue; a command during WAIT is ignored.
        send(24'h000213, 8'hA5, 32'h1111_2222, c0);
        expect_issue(4'b0100, 24'h000013, 8'hA5, 32'h1111_2222, c0 + 1);
        expect_res(32'hCAFE_F00D, 2'b00, c0 + 7);
        wait_to(c0 + 3);
        cmd_valid = 1'b1;
        addr = 24'h000100;
        tick();
        cmd_valid = 1'b0;
        wait_to(c0 + 6);
        pulse_done(2, 32'hCAFE_F00D);
        wait_to(c0 + 12);
        chk("result_hold",    result, 32'hCAFE_F00D);
        chk("status_hold",    status, 2'b00);
        chk("core_addr_hold", core_addr, 24'h000013);

        // Unmapped region.
        send(24'h000500, 8'h3C, 32'h0000_0055, c0);
        expect_res(32'h0, 2'b10, c0 + 1);
        wait_to(c0 + 4);

        // Core 1 silent: timeout 257 cycles after issue.
        send(24'h000100, 8'h01, 32'h0000_0077, c0);
        expect_issue(4'b0010, 24'h0, 8'h01, 32'h0000_0077, c0 + 1);
        expect_res(32'h0, 2'b01, c0 + 258);
        wait_to(c0 + 262);

        // Done on the timeout cycle wins.
        send(24'h000100, 8'h02, 32'h0000_0078, c0);
        expect_issue(4'b0010, 24'h0, 8'h02, 32'h0000_0078, c0 + 1);
        expect_res(32'h600D_F00D, 2'b00, c0 + 258);
        wait_to(c0 + 257);
        pulse_done(1, 32'h600D_F00D);
        wait_to(c0 + 261);

        // Done from a non-target core is ignored.
        send(24'h000000, 8'h44, 32'h0000_0099, c0);
        expect_issue(4'b0001, 24'h0, 8'h44, 32'h0000_0099, c0 + 1);
        wait_to(c0 + 3);
        pulse_done(3, 32'hBAD0_BAD0);
        wait_to(c0 + 6);
        expect_res(32'h1234_5678, 2'b00, c0 + 7);
        pulse_done(0, 32'h1234_5678);
        wait_to(c0 + 10);

        // Reset mid-WAIT aborts; a late done produces nothing.
        send(24'h000200, 8'h55, 32'h0000_00AA, c0);
        expect_issue(4'b0100, 24'h0, 8'h55, 32'h0000_00AA, c0 + 1);
        wait_to(c0 + 4);
        rst = 1'b1;
        #1;
        chk("midrst_ready",      cmd_ready, 0);
        chk("midrst_core_instr", core_instr, 0);
        tick();
        rst = 1'b0;
        wait_to(c0 + 6);
        pulse_done(2, 32'hDEAD_BEEF);
        wait_to(c0 + 10);
        send(24'h000001, 8'h66, 32'h0000_00BB, c1);
        expect_issue(4'b0001, 24'h000001, 8'h66, 32'h0000_00BB, c1 + 1);
        wait_to(c1 + 3);
        expect_res(32'h0BAD_CAFE, 2'b00, c1 + 4);
        pulse_done(0, 32'h0BAD_CAFE);
        wait_to(c1 + 7);

`ifdef DISPATCH_BROADCAST_EN
        // Broadcast, core 2 silent: timeout with done mask 1011.
        send(24'hFFFFFF, 8'h77, 32'h0000_00CC, c0);
        expect_issue(4'b1111, 24'h0, 8'h77, 32'h0000_00CC, c0 + 1);
        expect_res(32'h0000_000B, 2'b01, c0 + 258);
        wait_to(c0 + 3);
        pulse_done(0, 32'h1);
        pulse_done(1, 32'h2);
        wait_to(c0 + 8);
        pulse_done(3, 32'h3);
        wait_to(c0 + 262);

        // Broadcast, all cores done in two groups: sticky mask, result = 4.
        send(24'hFFFFFF, 8'h78, 32'h0000_00CD, c0);
        expect_issue(4'b1111, 24'h0, 8'h78, 32'h0000_00CD, c0 + 1);
        expect_res(32'h0000_0004, 2'b00, c0 + 6);
        wait_to(c0 + 3);
        core_done = 4'b0011;
        tick();
        core_done = 4'b0000;
        wait_to(c0 + 5);
        core_done = 4'b1100;
        tick();
        core_done = 4'b0000;
        wait_to(c0 + 9);
`else
        // All-ones address is an ordinary unmapped command.
        send(24'hFFFFFF, 8'h77, 32'h0000_00CC, c0);
        expect_res(32'h0, 2'b10, c0 + 1);
        wait_to(c0 + 4);
`endif

        chk("issue_queue_empty",  64'(exp_iss.size()), 0);
        chk("result_queue_empty", 64'(exp_res.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
